fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU. Tracks in-flight register writes in a DEPTH-entry shift-register scoreboard, one entry per stage after ID. Issues registered per-operand bypass selects to the EX-stage operand muxes and a combinational stall to the IF/ID and PC registers. Generalises the fixed two-source, EX/MEM-only forwarding check to N sources, configurable depth, load-use detection and flush.

## Interface
Parameters:
- REG_AW, 4: register-address width.
- NSRC, 2: source operands per instruction.
- DEPTH, 3: scoreboard stages after ID. Entry 0 = EX, 1 = MEM, 2 = WB. Legal range 2..8.
- SEL_W, $clog2(DEPTH): width of one bypass select.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  a valid instruction is in ID.
- id_src  in  NSRC*REG_AW  source register numbers; operand i is at [i*REG_AW +: REG_AW].
- id_src_use  in  NSRC  operand i is actually read.
- id_dst  in  REG_AW  destination register.
- id_wr  in  1  instruction writes id_dst.
- id_load  in  1  result exists only at the end of MEM (LW).
- flush  in  1  kill the instructions in ID and in EX (taken branch).
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- ex_fwd_sel  out  NSRC*SEL_W  registered bypass select per operand for the instruction now in EX. 0 = register file, k = result of the stage k positions ahead.

## Operation
- Scoreboard entry: {vld, wr, load, dst}. A bubble is all zeros.
- Entry e is a producer for source s when all of these hold:
  - vld & wr;
  - dst == s;
  - s != 0 (R0 is never forwarded and never stalls);
  - the operand's id_src_use bit is set.
- Stall, when flush = 0: id_valid and entry 0 is a producer with load = 1, for any used operand. When flush = 1, stall = 0.
- Select for operand i, computed in ID: scan entries 0..DEPTH-2 for producers. The lowest index j wins (youngest value), giving select j+1. With no producer the select is 0.
  - Entry DEPTH-1 is never forwarded. The register file writes before it reads.
- Every edge:
  - entry[k] <= entry[k-1] for k >= 1;
  - entry[0] <= {1, id_wr, id_load, id_dst} when id_valid & !stall & !flush, else a bubble.
- ex_fwd_sel is loaded with the computed selects when an instruction is inserted. It is loaded with 0 when a bubble is inserted.
- On flush, entry[1] receives a bubble instead of entry[0]. The killed EX instruction never forwards.
- A load producer sitting in entry 1 forwards normally with select 2 (MEM/WB value). No stall is needed.

## Timing
- Reset: all entries are bubbles, ex_fwd_sel = 0, stall = 0. This holds while rst is asserted, whatever the other inputs are.
- stall is valid in the same cycle as the ID inputs. ex_fwd_sel is valid one cycle later, during that instruction's EX cycle.
- A load-use stall lasts exactly one cycle. Afterwards the load sits in entry 1 and the dependant gets select 2.
- flush and stall in the same cycle: flush wins, stall = 0, and a bubble is inserted.
- rst mid-operation clears all in-flight entries at once. No stale forward appears after rst is released.
- Back-to-back writers to the same register: the youngest wins.

## Configuration
- FWD_STALL_CNT_EN defined:
  - adds output stall_cnt (16 bits);
  - it increments on every cycle with stall = 1 and saturates at 16'hFFFF;
  - reset value 0.
- Not defined: the port and the counter do not exist. All other behaviour is identical.

## Test plan
- ADD R3 then ADD R5,R3,R3 back-to-back -> no stall; in the EX cycle both selects = 1.
- ADD R3, NOP, SUB R6,R3,R1 -> operand 0 select = 2, operand 1 select = 0.
- LW R4 then ADD R7,R4,R2 -> stall = 1 for one cycle with a bubble in EX, then operand 0 select = 2.
- Writer to R0 followed by a reader of R0 -> never stalls, select = 0. A reader with id_src_use = 0 on a matching register -> select 0.
- LW R4 followed by a dependant with flush asserted in the same cycle -> stall = 0. The next cycle both entries 0 and 1 are bubbles and ex_fwd_sel = 0.
- Assert rst with three writers in flight, release, then issue a reader of their registers -> select 0 and no stall. With FWD_STALL_CNT_EN, three load-use stalls give stall_cnt = 3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: scoreboard-based operand bypass selects and load-use stall for an N-source pipeline.
// Optional FWD_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module fwd_hazard_unit #(
  parameter int REG_AW = 4,
  parameter int NSRC = 2,
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NSRC*REG_AW-1:0]  id_src,
  input  logic [NSRC-1:0]         id_src_use,
  input  logic [REG_AW-1:0]       id_dst,
  input  logic                    id_wr,
  input  logic                    id_load,
  input  logic                    flush,
  output logic                    stall,
  output logic [NSRC*SEL_W-1:0]   ex_fwd_sel
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);
  logic [DEPTH-1:0] vld, wr, ld;
  logic [REG_AW-1:0] dst [DEPTH];
  logic [NSRC*DEPTH-1:0] hit;
  logic [NSRC*SEL_W-1:0] sel;
  logic [NSRC-1:0] lu;
  logic ins;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    for (genvar j = 0; j < DEPTH; j++) begin : g_ent
      assign hit[i*DEPTH+j] = vld[j] & wr[j] & id_src_use[i] & |id_src[i*REG_AW +: REG_AW]
                              & (dst[j] == id_src[i*REG_AW +: REG_AW]);
    end
  end
  // Scan oldest to youngest so the youngest forwardable producer overwrites; WB entry is excluded.
  always_comb begin
    sel = '0;
    lu = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = DEPTH - 2; j >= 0; j--)
        if (hit[i*DEPTH+j]) sel[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
      lu[i] = hit[i*DEPTH] & ld[0];
    end
  end
  assign stall = id_valid & ~flush & |lu;
  assign ins = id_valid & ~stall & ~flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      wr <= '0;
      ld <= '0;
      dst <= '{default: '0};
      ex_fwd_sel <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        wr[k] <= wr[k-1];
        ld[k] <= ld[k-1];
        dst[k] <= dst[k-1];
      end
      if (flush) begin
        vld[1] <= 1'b0;
        wr[1] <= 1'b0;
        ld[1] <= 1'b0;
        dst[1] <= '0;
      end
      vld[0] <= ins;
      wr[0] <= ins & id_wr;
      ld[0] <= ins & id_load;
      dst[0] <= ins ? id_dst : '0;
      ex_fwd_sel <= ins ? sel : '0;
    end
  end
`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of bypass selects, load-use stall, flush and reset.
module tb_fwd_hazard_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, id_wr = 1'b0, id_load = 1'b0, flush = 1'b0;
  logic [7:0] id_src = '0;
  logic [1:0] id_src_use = '0;
  logic [3:0] id_dst = '0;
  logic stall;
  logic [3:0] ex_fwd_sel;
  int errors = 0, checks = 0;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] cnt0;
`endif
  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .flush(flush),
    .stall(stall), .ex_fwd_sel(ex_fwd_sel)
`ifdef FWD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] u, input logic [3:0] d, input logic w,
                       input logic l, input logic f);
    id_valid = v; id_src = {s1, s0}; id_src_use = u; id_dst = d;
    id_wr = w; id_load = l; flush = f;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask
  task automatic test_reset();
    drive(1, 4, 4, 2'b11, 4, 1, 1, 0);
    repeat (2) step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got=%h exp=0", ex_fwd_sel); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    idle();
  endtask
  task automatic test_back_to_back();
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0);
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL b2b_first_sel got=%h exp=0", ex_fwd_sel); end
    drive(1, 3, 3, 2'b11, 5, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_fwd_sel !== 4'b0101) begin errors++; $display("FAIL b2b_sel got=%h exp=5", ex_fwd_sel); end
    idle();
  endtask
  task automatic test_gap();
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 3, 1, 2'b11, 6, 1, 0, 0);
    step();
    checks++; if (ex_fwd_sel !== 4'b0010) begin errors++; $display("FAIL gap_sel got=%h exp=2", ex_fwd_sel); end
    idle();
  endtask
  task automatic test_load_use();
    drive(1, 1, 0, 2'b01, 4, 1, 1, 0);
    step();
`ifdef FWD_STALL_CNT_EN
    cnt0 = stall_cnt;
`endif
    drive(1, 4, 2, 2'b11, 7, 1, 0, 0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL lu_bubble_sel got=%h exp=0", ex_fwd_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got=%b exp=0", stall); end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cnt !== cnt0 + 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, cnt0 + 16'd1); end
`endif
    step();
    checks++; if (ex_fwd_sel !== 4'b0010) begin errors++; $display("FAIL lu_sel got=%h exp=2", ex_fwd_sel); end
    idle();
  endtask
  task automatic test_r0();
    drive(1, 1, 0, 2'b01, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 2'b11, 5, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL r0_sel got=%h exp=0", ex_fwd_sel); end
    idle();
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0);
    step();
    drive(1, 3, 3, 2'b00, 5, 1, 0, 0);
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL nouse_sel got=%h exp=0", ex_fwd_sel); end
    idle();
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0);
    step();
    drive(1, 3, 3, 2'b10, 5, 1, 0, 0);
    step();
    checks++; if (ex_fwd_sel !== 4'b0100) begin errors++; $display("FAIL use1_sel got=%h exp=4", ex_fwd_sel); end
    idle();
  endtask
  task automatic test_flush();
    drive(1, 1, 0, 2'b01, 4, 1, 1, 0);
    step();
    drive(1, 4, 2, 2'b11, 7, 1, 0, 1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL flush_sel got=%h exp=0", ex_fwd_sel); end
    drive(1, 4, 4, 2'b11, 8, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL flush_after_sel got=%h exp=0", ex_fwd_sel); end
    idle();
  endtask
  task automatic test_rst_mid();
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0);
    step();
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0);
    step();
    drive(1, 2, 0, 2'b01, 3, 1, 1, 0);
    step();
    checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL rst_pre_sel got=%h exp=1", ex_fwd_sel); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL rst_async_sel got=%h exp=0", ex_fwd_sel); end
    rst = 1'b0;
    drive(1, 3, 2, 2'b11, 9, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_post_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_fwd_sel !== 4'h0) begin errors++; $display("FAIL rst_post_sel got=%h exp=0", ex_fwd_sel); end
    idle();
  endtask
  task automatic test_youngest();
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
    step();
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
    step();
    drive(1, 3, 0, 2'b01, 6, 1, 0, 0);
    step();
    checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL youngest_sel got=%h exp=1", ex_fwd_sel); end
    idle();
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_load_use();
    test_r0();
    test_flush();
    test_rst_mid();
    test_youngest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
